// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter that lets two masters share one slave bus. Ownership is
// granted in IDLE and held for exactly one transaction, which ends with
// bus_ready, with the owner dropping its request (abort) or, optionally, with
// a watchdog timeout. The request path is muxed combinationally from the
// owning master. The response path (bus_ready/bus_dat_i) reaches the owner in
// the same cycle.
//
// Optional feature (compile-time macro): ARB_TIMEOUT_EN
//   defined   : an 8-bit watchdog aborts an owned transaction after TIMEOUT
//               cycles without bus_ready. The owner gets a ready pulse with
//               32'hDEADBEEF and arb_err pulses for one cycle.
//   undefined : no watchdog, arb_err is tied to 0.
//
// Parameters
//   XLEN        data/address width
//   SLAVE_WIDTH width of the slave-select field
//   TIMEOUT     watchdog limit in cycles (1..255), used with ARB_TIMEOUT_EN
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous active-low reset
//   mN_req/wen/mode/addr/num/dat_o   master N request fields (inputs)
//   mN_dat_i, mN_ready  response to master N
//   bus_req/wen/mode/addr/num/dat_o  slave-side request
//   bus_dat_i, bus_ready            slave-side response
//   arb_err             one-cycle watchdog timeout pulse
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned SLAVE_WIDTH = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      m0_req,
    input  logic                      m0_wen,
    input  logic [2:0]                m0_mode,
    input  logic [XLEN-SLAVE_WIDTH-1:0] m0_addr,
    input  logic [SLAVE_WIDTH-1:0]    m0_num,
    input  logic [XLEN-1:0]           m0_dat_o,
    output logic [XLEN-1:0]           m0_dat_i,
    output logic                      m0_ready,

    input  logic                      m1_req,
    input  logic                      m1_wen,
    input  logic [2:0]                m1_mode,
    input  logic [XLEN-SLAVE_WIDTH-1:0] m1_addr,
    input  logic [SLAVE_WIDTH-1:0]    m1_num,
    input  logic [XLEN-1:0]           m1_dat_o,
    output logic [XLEN-1:0]           m1_dat_i,
    output logic                      m1_ready,

    output logic                      bus_req,
    output logic                      bus_wen,
    output logic [2:0]                bus_mode,
    output logic [XLEN-SLAVE_WIDTH-1:0] bus_addr,
    output logic [SLAVE_WIDTH-1:0]    bus_num,
    output logic [XLEN-1:0]           bus_dat_o,
    input  logic [XLEN-1:0]           bus_dat_i,
    input  logic                      bus_ready,

    output logic                      arb_err
);

    localparam logic [XLEN-1:0] DEAD_WORD = XLEN'(32'hDEADBEEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;     // index of the master served most recently
    logic   timeout;            // watchdog fires this cycle (never with bus_ready)

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // The counter holds the number of completed waiting cycles, so the
    // TIMEOUT-th owned cycle is the one that sees TIMEOUT-1 here.
    assign timeout = (state_q != IDLE) && !bus_ready && (cnt_q == 8'(TIMEOUT - 1));

    // Cleared on entry to (and exit from) ownership, counts while owned.
    always_comb begin
        cnt_d = '0;
        if (state_q != IDLE && state_d != IDLE) begin
            cnt_d = cnt_q + 8'd1;
        end
    end
`else
    logic [7:0] unused_timeout;

    assign unused_timeout = 8'(TIMEOUT);
    assign timeout        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // On a tie the master that was not served last wins.
                if (m0_req && (!m1_req || last_q)) begin
                    state_d = OWN0;
                end else if (m1_req) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (bus_ready || !m0_req || timeout) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            OWN1: begin
                if (bus_ready || !m1_req || timeout) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Request mux and response routing; everything is 0 in IDLE, so the
    // asynchronous reset clears every output at once.
    // ------------------------------------------------------------------
    always_comb begin
        bus_req   = 1'b0;
        bus_wen   = 1'b0;
        bus_mode  = '0;
        bus_addr  = '0;
        bus_num   = '0;
        bus_dat_o = '0;
        m0_ready  = 1'b0;
        m0_dat_i  = '0;
        m1_ready  = 1'b0;
        m1_dat_i  = '0;
        case (state_q)
            OWN0: begin
                bus_req   = m0_req && !timeout;
                bus_wen   = m0_wen;
                bus_mode  = m0_mode;
                bus_addr  = m0_addr;
                bus_num   = m0_num;
                bus_dat_o = m0_dat_o;
                m0_ready  = bus_ready || timeout;
                m0_dat_i  = timeout ? DEAD_WORD : bus_dat_i;
            end
            OWN1: begin
                bus_req   = m1_req && !timeout;
                bus_wen   = m1_wen;
                bus_mode  = m1_mode;
                bus_addr  = m1_addr;
                bus_num   = m1_num;
                bus_dat_o = m1_dat_o;
                m1_ready  = bus_ready || timeout;
                m1_dat_i  = timeout ? DEAD_WORD : bus_dat_i;
            end
            default: begin
            end
        endcase
    end

    assign arb_err = timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter: directed self-checking bench for bus_arbiter.
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later,
// well before the next edge. Built with or without ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_wen, m1_req, m1_wen;
    logic [2:0]  m0_mode, m1_mode;
    logic [27:0] m0_addr, m1_addr;
    logic [3:0]  m0_num, m1_num;
    logic [31:0] m0_dat_o, m1_dat_o, m0_dat_i, m1_dat_i;
    logic        m0_ready, m1_ready;
    logic        bus_req, bus_wen, bus_ready, arb_err;
    logic [2:0]  bus_mode;
    logic [27:0] bus_addr;
    logic [3:0]  bus_num;
    logic [31:0] bus_dat_o, bus_dat_i;

    int errors = 0;
    int checks = 0;

    bus_arbiter #(.XLEN(32), .SLAVE_WIDTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_mode(m0_mode), .m0_addr(m0_addr),
        .m0_num(m0_num), .m0_dat_o(m0_dat_o), .m0_dat_i(m0_dat_i), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_mode(m1_mode), .m1_addr(m1_addr),
        .m1_num(m1_num), .m1_dat_o(m1_dat_o), .m1_dat_i(m1_dat_i), .m1_ready(m1_ready),
        .bus_req(bus_req), .bus_wen(bus_wen), .bus_mode(bus_mode), .bus_addr(bus_addr),
        .bus_num(bus_num), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
        .bus_ready(bus_ready), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_req = 0; m0_wen = 0; m0_mode = 3'b010; m0_addr = 28'h10; m0_num = 4'd1; m0_dat_o = 32'h0;
        m1_req = 0; m1_wen = 0; m1_mode = 3'b000; m1_addr = 28'h20; m1_num = 4'd2; m1_dat_o = 32'h0;
        bus_ready = 0; bus_dat_i = 32'h0;
        #2;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b expected 0", bus_req); end
        checks++; if ({m0_ready, m1_ready, arb_err} !== 3'b000) begin errors++; $display("FAIL reset_ready_err: got %b expected 000", {m0_ready, m1_ready, arb_err}); end
        checks++; if (bus_dat_o !== 32'h0 || bus_num !== 4'h0) begin errors++; $display("FAIL reset_bus_fields: got %h/%h expected 0/0", bus_dat_o, bus_num); end
        step(); step();
        rst = 1'b1;
    endtask

    task automatic test_single_master();
        m0_req = 1;
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL single_latency: got %b expected 0", bus_req); end
        step();  // grant edge
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL single_bus_req: got %b expected 1", bus_req); end
        checks++; if (bus_addr !== 28'h10 || bus_num !== 4'd1 || bus_mode !== 3'b010 || bus_wen !== 1'b0)
            begin errors++; $display("FAIL single_fields: got %h/%h/%b/%b expected 0000010/1/010/0", bus_addr, bus_num, bus_mode, bus_wen); end
        step();
        checks++; if (bus_req !== 1'b1 || m0_ready !== 1'b0) begin errors++; $display("FAIL single_wait: got req=%b rdy=%b expected 1/0", bus_req, m0_ready); end
        step();
        bus_ready = 1; bus_dat_i = 32'h12345678;
        #1;
        checks++; if (m0_ready !== 1'b1 || m0_dat_i !== 32'h12345678) begin errors++; $display("FAIL single_resp: got %b/%h expected 1/12345678", m0_ready, m0_dat_i); end
        checks++; if (m1_ready !== 1'b0 || m1_dat_i !== 32'h0) begin errors++; $display("FAIL single_m1_quiet: got %b/%h expected 0/0", m1_ready, m1_dat_i); end
        step();
        bus_ready = 0; m0_req = 0;
        #1;
        checks++; if (bus_req !== 1'b0 || m0_ready !== 1'b0) begin errors++; $display("FAIL single_idle_gap: got %b/%b expected 0/0", bus_req, m0_ready); end
    endtask

    task automatic test_alternation();
        rst = 0; #2; rst = 1;
        step();
        m0_req = 1; m1_req = 1;
        for (int i = 0; i < 6; i++) begin
            step();  // IDLE -> OWNx
            checks++; if (bus_req !== 1'b1 || bus_num !== ((i % 2 == 0) ? 4'd1 : 4'd2))
                begin errors++; $display("FAIL alt_owner%0d: got req=%b num=%h expected 1/%0d", i, bus_req, bus_num, (i % 2 == 0) ? 1 : 2); end
            bus_ready = 1; bus_dat_i = 32'hA000_0000 + 32'(i);
            #1;
            if (i % 2 == 0) begin
                checks++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || m0_dat_i !== 32'hA000_0000 + 32'(i))
                    begin errors++; $display("FAIL alt_resp%0d: got %b/%b/%h expected 1/0/%h", i, m0_ready, m1_ready, m0_dat_i, 32'hA000_0000 + 32'(i)); end
            end else begin
                checks++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || m1_dat_i !== 32'hA000_0000 + 32'(i))
                    begin errors++; $display("FAIL alt_resp%0d: got %b/%b/%h expected 1/0/%h", i, m1_ready, m0_ready, m1_dat_i, 32'hA000_0000 + 32'(i)); end
            end
            step();  // OWNx -> IDLE
            bus_ready = 0;
            #1;
            checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL alt_gap%0d: got %b expected 0", i, bus_req); end
        end
        m0_req = 0; m1_req = 0;
        step();
    endtask

    task automatic test_field_isolation();
        m0_wen = 0; m0_num = 4'd5; m0_addr = 28'h55; m0_dat_o = 32'h11111111; m0_mode = 3'b001;
        m1_wen = 1; m1_num = 4'd2; m1_addr = 28'h20; m1_dat_o = 32'hCAFEF00D; m1_mode = 3'b010;
        m1_req = 1;
        step();  // -> OWN1
        m0_req = 1;  // m0 arrives while m1 owns the bus
        #1;
        checks++; if (bus_dat_o !== 32'hCAFEF00D || bus_num !== 4'd2 || bus_wen !== 1'b1 || bus_addr !== 28'h20)
            begin errors++; $display("FAIL iso_fields: got %h/%h/%b/%h expected CAFEF00D/2/1/0000020", bus_dat_o, bus_num, bus_wen, bus_addr); end
        bus_ready = 1; bus_dat_i = 32'h0BADF00D;
        #1;
        checks++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || m0_dat_i !== 32'h0)
            begin errors++; $display("FAIL iso_ready: got m1=%b m0=%b m0dat=%h expected 1/0/0", m1_ready, m0_ready, m0_dat_i); end
        step();
        bus_ready = 0; m1_req = 0;
        step();  // -> OWN0 (m0 only)
        checks++; if (bus_num !== 4'd5 || bus_dat_o !== 32'h11111111 || bus_wen !== 1'b0)
            begin errors++; $display("FAIL iso_m0_fields: got %h/%h/%b expected 5/11111111/0", bus_num, bus_dat_o, bus_wen); end
        bus_ready = 1;
        step();
        bus_ready = 0; m0_req = 0;
        step();  // last = 0 now
    endtask

    task automatic test_reset_mid();
        m0_req = 1;
        step();  // -> OWN0
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rmid_own: got %b expected 1", bus_req); end
        #1; rst = 0; bus_ready = 1; bus_dat_i = 32'h77777777;
        #1;
        checks++; if (bus_req !== 1'b0 || bus_num !== 4'd0 || bus_dat_o !== 32'h0)
            begin errors++; $display("FAIL rmid_async: got %b/%h/%h expected 0/0/0", bus_req, bus_num, bus_dat_o); end
        checks++; if (m0_ready !== 1'b0 || m0_dat_i !== 32'h0) begin errors++; $display("FAIL rmid_ready: got %b/%h expected 0/0", m0_ready, m0_dat_i); end
        bus_ready = 0;
        step();
        rst = 1; m1_req = 1;
        step();  // tie after reset -> m0
        checks++; if (bus_req !== 1'b1 || bus_num !== 4'd5) begin errors++; $display("FAIL rmid_tie: got %b/%h expected 1/5", bus_req, bus_num); end
        bus_ready = 1;
        step();
        bus_ready = 0; m0_req = 0; m1_req = 0;
        step();  // m1 was granted here? no: m1_req sampled low at this edge
    endtask

    task automatic test_idle_and_abort();
        bus_ready = 1;
        #1;
        checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b/%b expected 0/0", m0_ready, m1_ready); end
        step();
        bus_ready = 0;
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL idle_stays: got %b expected 0", bus_req); end
        m0_req = 1;
        step();  // -> OWN0
        m0_req = 0;  // abort
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL abort_req: got %b expected 0", bus_req); end
        step();  // -> IDLE, last = 0
        bus_ready = 1;
        #1;
        checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL abort_late_ready: got %b expected 0", m0_ready); end
        bus_ready = 0; m0_req = 1; m1_req = 1;
        step();  // tie after m0 abort -> m1
        checks++; if (bus_num !== 4'd2 || bus_req !== 1'b1) begin errors++; $display("FAIL abort_next_tie: got %h/%b expected 2/1", bus_num, bus_req); end
        bus_ready = 1;
        step();
        bus_ready = 0; m0_req = 0; m1_req = 0;
        step();
    endtask

    task automatic test_timeout();
        bus_dat_i = 32'h0;
        m0_req = 1;
        step();  // -> OWN0, owned cycle 1
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c < 8; c++) begin
            checks++; if (m0_ready !== 1'b0 || arb_err !== 1'b0 || bus_req !== 1'b1)
                begin errors++; $display("FAIL to_wait%0d: got %b/%b/%b expected 0/0/1", c, m0_ready, arb_err, bus_req); end
            step();
        end
        checks++; if (m0_ready !== 1'b1 || m0_dat_i !== 32'hDEADBEEF || arb_err !== 1'b1 || bus_req !== 1'b0)
            begin errors++; $display("FAIL to_fire: got %b/%h/%b/%b expected 1/DEADBEEF/1/0", m0_ready, m0_dat_i, arb_err, bus_req); end
        step();
        checks++; if (arb_err !== 1'b0 || bus_req !== 1'b0 || m0_ready !== 1'b0)
            begin errors++; $display("FAIL to_idle: got %b/%b/%b expected 0/0/0", arb_err, bus_req, m0_ready); end
        m0_req = 0;
        step();
        // collision: bus_ready in the 8th owned cycle
        m0_req = 1;
        step();
        for (int c = 1; c < 8; c++) step();
        bus_ready = 1; bus_dat_i = 32'hA5A5A5A5;
        #1;
        checks++; if (m0_ready !== 1'b1 || m0_dat_i !== 32'hA5A5A5A5 || arb_err !== 1'b0)
            begin errors++; $display("FAIL to_collide: got %b/%h/%b expected 1/A5A5A5A5/0", m0_ready, m0_dat_i, arb_err); end
        step();
        bus_ready = 0; m0_req = 0;
        step();
`else
        for (int c = 1; c <= 20; c++) begin
            if (c == 8 || c == 20) begin
                checks++; if (bus_req !== 1'b1 || m0_ready !== 1'b0 || arb_err !== 1'b0)
                    begin errors++; $display("FAIL noto_hold%0d: got %b/%b/%b expected 1/0/0", c, bus_req, m0_ready, arb_err); end
            end
            step();
        end
        bus_ready = 1;
        step();
        bus_ready = 0; m0_req = 0;
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL noto_release: got %b expected 0", bus_req); end
        step();
`endif
    endtask

    initial begin
        test_reset();
        step();
        test_single_master();
        test_alternation();
        test_field_isolation();
        test_reset_mid();
        test_idle_and_abort();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
